// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with an optional result accumulator.
// S1 holds the operands, S2 holds the registered result and its flags.
module logic_unit_pipe #(
  parameter int WIDTH  = 4,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Sel,
  input  logic             Acc,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Zero,
  output logic             Parity
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0] aReg_q, bReg_q;
  logic [2:0]       selReg_q;
  logic             accReg_q;

  logic             s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0] out_q;
  logic             zero_q, parity_q;
  logic [WIDTH-1:0] accum_q;

  logic             s2Load, interlock, inFire;
  logic [WIDTH-1:0] opA, result;

  // An Acc transaction must wait until its predecessor has left S1, so that
  // the accumulator already holds that predecessor's result when it is used.
  always_comb begin
    s2Load    = s1Valid_q && (!s2Valid_q || Out_Ready);
    interlock = ACC_EN && In_Valid && Acc && s1Valid_q;
    In_Ready  = !rst && (!s1Valid_q || s2Load) && !interlock;
    inFire    = In_Valid && In_Ready;
    s1Valid_d = inFire ? 1'b1 : (s2Load ? 1'b0 : s1Valid_q);
    s2Valid_d = s2Load ? 1'b1 : ((s2Valid_q && Out_Ready) ? 1'b0 : s2Valid_q);
  end

  always_comb begin
    opA = (ACC_EN && accReg_q) ? accum_q : aReg_q;
    unique case (selReg_q)
      OP_AND:  result = opA & bReg_q;
      OP_OR:   result = opA | bReg_q;
      OP_XOR:  result = opA ^ bReg_q;
      OP_XNOR: result = ~(opA ^ bReg_q);
      OP_NAND: result = ~(opA & bReg_q);
      OP_NOR:  result = ~(opA | bReg_q);
      OP_NOTA: result = ~opA;
      OP_PASS: result = bReg_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      aReg_q    <= '0;
      bReg_q    <= '0;
      selReg_q  <= '0;
      accReg_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (inFire) begin
        aReg_q   <= A;
        bReg_q   <= B;
        selReg_q <= Sel;
        accReg_q <= Acc;
      end
    end
  end

  // Zero resets high because the cleared result is all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      out_q     <= '0;
      zero_q    <= 1'b1;
      parity_q  <= 1'b0;
      accum_q   <= '0;
    end else begin
      s2Valid_q <= s2Valid_d;
      if (s2Load) begin
        out_q    <= result;
        zero_q   <= (result == '0);
        parity_q <= ^result;
        accum_q  <= result;
      end
    end
  end

  assign Out       = out_q;
  assign Out_Valid = s2Valid_q;
  assign Zero      = zero_q;
  assign Parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed vectors push expected results,
// a negedge monitor pops and compares each output handshake.
module tb_logic_unit_pipe;

  typedef struct {
    logic [3:0] out;
    int         issueCycle;
    bit         checkLat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] aIn, bIn, outData;
  logic [2:0] selIn;
  logic       accIn, inVal, inRdy, outVal, outRdy, zeroOut, parOut;

  logic        wVal, wRdy1, wRdy16, wOutVal1, wOutVal16;
  logic        wZero1, wPar1, wZero16, wPar16;
  logic [0:0]  wA1, wB1, wOut1;
  logic [15:0] wA16, wB16, wOut16;
  logic [2:0]  wSel;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycleCnt = 0;
  int   stalls;

  logic_unit_pipe #(.WIDTH(4), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .A(aIn), .B(bIn), .Sel(selIn), .Acc(accIn),
    .In_Valid(inVal), .In_Ready(inRdy), .Out(outData), .Out_Valid(outVal),
    .Out_Ready(outRdy), .Zero(zeroOut), .Parity(parOut)
  );

  logic_unit_pipe #(.WIDTH(1), .ACC_EN(1'b1)) dutW1 (
    .clk(clk), .rst(rst), .A(wA1), .B(wB1), .Sel(wSel), .Acc(1'b0),
    .In_Valid(wVal), .In_Ready(wRdy1), .Out(wOut1), .Out_Valid(wOutVal1),
    .Out_Ready(1'b1), .Zero(wZero1), .Parity(wPar1)
  );

  // Acc is driven high here on purpose: with ACC_EN=0 it must be ignored.
  logic_unit_pipe #(.WIDTH(16), .ACC_EN(1'b0)) dutW16 (
    .clk(clk), .rst(rst), .A(wA16), .B(wB16), .Sel(wSel), .Acc(1'b1),
    .In_Valid(wVal), .In_Ready(wRdy16), .Out(wOut16), .Out_Valid(wOutVal16),
    .Out_Ready(1'b1), .Zero(wZero16), .Parity(wPar16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Holds the transaction on the inputs until accepted, counting stall cycles.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] sel, input logic acc,
                               input logic [3:0] expOut, input bit lat,
                               output int stallCnt);
    bit accepted = 0;
    stallCnt = 0;
    aIn = a; bIn = b; selIn = sel; accIn = acc; inVal = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (inRdy) begin
        accepted = 1;
        sb.push_back('{expOut, cycleCnt, lat});
      end else begin
        stallCnt++;
      end
      @(posedge clk); #1;
    end
    inVal = 1'b0; accIn = 1'b0;
    if (!accepted) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout: got no In_Ready expected acceptance");
    end
  endtask

  task automatic drainPipe();
    int n = 0;
    while ((sb.size() != 0 || outVal) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && outVal && outRdy) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_output: got %0h expected none", outData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out", outData, e.out);
        checkOutput("zero", zeroOut, e.out == 4'b0);
        checkOutput("parity", parOut, ^e.out);
        if (e.checkLat) checkOutput("latency", cycleCnt - e.issueCycle, 2);
      end
    end
  end

  initial begin
    logic [3:0]  basicExp [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                                  4'b0111, 4'b0001, 4'b0011, 4'b1010};
    logic [15:0] vA16 [3] = '{16'hFFFF, 16'h1234, 16'hABCD};
    logic [15:0] vB16 [3] = '{16'h00FF, 16'h0F0F, 16'hFFFF};
    logic [15:0] vE16 [3] = '{16'hFF00, 16'h0204, 16'h5432};
    logic [0:0]  vA1 [3] = '{1'b1, 1'b1, 1'b0};
    logic [0:0]  vB1 [3] = '{1'b1, 1'b0, 1'b0};
    logic [0:0]  vE1 [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  vSel [3] = '{3'b100, 3'b000, 3'b010};
    logic [2:0]  vSel1 [3] = '{3'b000, 3'b101, 3'b011};

    rst = 1'b1; aIn = '0; bIn = '0; selIn = '0; accIn = 1'b0; inVal = 1'b0;
    outRdy = 1'b1; wVal = 1'b0; wA1 = '0; wB1 = '0; wA16 = '0; wB16 = '0; wSel = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", outVal, 1'b0);
    checkOutput("rst_out", outData, 4'b0);
    checkOutput("rst_zero", zeroOut, 1'b1);
    checkOutput("rst_parity", parOut, 1'b0);
    checkOutput("rst_in_ready", inRdy, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_rst", inRdy, 1'b1);
    @(posedge clk); #1;

    $display("[TB] basic ops back-to-back");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1100, 4'b1010, 3'(i), 1'b0, basicExp[i], 1'b1, stalls);
      checkOutput("basic_stall", stalls, 0);
    end
    drainPipe();

    $display("[TB] flags");
    applyStimulus(4'b0101, 4'b0101, 3'b010, 1'b0, 4'b0000, 1'b0, stalls);
    applyStimulus(4'b0101, 4'b0101, 3'b001, 1'b0, 4'b0101, 1'b0, stalls);
    applyStimulus(4'b0001, 4'b0101, 3'b110, 1'b0, 4'b1110, 1'b0, stalls);
    drainPipe();

    $display("[TB] backpressure");
    outRdy = 1'b0;
    applyStimulus(4'b0011, 4'b0101, 3'b000, 1'b0, 4'b0001, 1'b0, stalls);
    applyStimulus(4'b0011, 4'b0101, 3'b001, 1'b0, 4'b0111, 1'b0, stalls);
    aIn = 4'b0011; bIn = 4'b0101; selIn = 3'b010; inVal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", inRdy, 1'b0);
      checkOutput("bp_out_valid", outVal, 1'b1);
      checkOutput("bp_out_held", outData, 4'b0001);
      @(posedge clk); #1;
    end
    outRdy = 1'b1;
    applyStimulus(4'b0011, 4'b0101, 3'b010, 1'b0, 4'b0110, 1'b0, stalls);
    checkOutput("bp_release_stall", stalls, 0);
    drainPipe();

    $display("[TB] accumulate");
    applyStimulus(4'b1111, 4'b0000, 3'b111, 1'b0, 4'b0000, 1'b0, stalls);
    applyStimulus(4'b1111, 4'b0011, 3'b010, 1'b1, 4'b0011, 1'b0, stalls);
    checkOutput("acc1_stall", stalls, 1);
    applyStimulus(4'b1111, 4'b0001, 3'b010, 1'b1, 4'b0010, 1'b0, stalls);
    checkOutput("acc2_stall", stalls, 1);
    drainPipe();

    $display("[TB] async reset mid-operation");
    outRdy = 1'b0;
    applyStimulus(4'b0110, 4'b1001, 3'b001, 1'b0, 4'b1111, 1'b0, stalls);
    applyStimulus(4'b0110, 4'b1001, 3'b011, 1'b0, 4'b0000, 1'b0, stalls);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", outVal, 1'b0);
    checkOutput("arst_out", outData, 4'b0);
    checkOutput("arst_zero", zeroOut, 1'b1);
    checkOutput("arst_in_ready", inRdy, 1'b0);
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b0; outRdy = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", inRdy, 1'b1);
    checkOutput("post_rst_no_output", outVal, 1'b0);
    @(posedge clk); #1;
    applyStimulus(4'b1010, 4'b0110, 3'b010, 1'b1, 4'b0110, 1'b1, stalls);
    checkOutput("post_rst_stall", stalls, 0);
    drainPipe();

    $display("[TB] WIDTH=1 and WIDTH=16");
    for (int i = 0; i < 3; i++) begin
      wA1 = vA1[i]; wB1 = vB1[i]; wA16 = vA16[i]; wB16 = vB16[i];
      wSel = vSel[i]; wVal = 1'b1;
      if (i == 0) wSel = 3'b100;
      @(negedge clk);
      checkOutput("w16_in_ready", wRdy16, 1'b1);
      @(posedge clk); #1;
      wVal = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("w16_valid", wOutVal16, 1'b1);
      checkOutput("w16_out", wOut16, vE16[i]);
      @(posedge clk); #1;
      wSel = vSel1[i]; wVal = 1'b1;
      @(posedge clk); #1;
      wVal = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("w1_valid", wOutVal1, 1'b1);
      checkOutput("w1_out", wOut1, vE1[i]);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("[TB] FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
